// File: rtl/csr_hpm_counter.sv
// ============================================================================
// csr_hpm_counter
// ----------------------------------------------------------------------------
// Machine hardware performance counter bank. It holds mcycle, minstret and
// NUM_HPM event counters (mhpmcounter3..), each with an mhpmevent selector
// and an mcountinhibit bit. It shares the exu CSR read/write port with the
// core CSR file. csr_hit_o tells the CSR file that this block owns the read
// address and drives csr_rdata_o.
//
// Optional feature macro: HPM_OVF_IRQ_EN
//   When defined, each counter has a sticky overflow flag. The flags are
//   visible and clearable through custom CSR mcounterovf (0x7C0), and a
//   registered overflow interrupt is raised while any flag is set.
//   When undefined, there is no overflow state, 0x7C0 is not owned and
//   ovf_irq_o is tied low.
//
// Ports
//   clk           : clock
//   rst           : synchronous active-high reset
//   csr_we_i      : CSR write strobe (already qualified by exu)
//   csr_waddr_i   : CSR write address
//   csr_wdata_i   : CSR write data (final value after set/clear resolution)
//   csr_raddr_i   : CSR read address
//   csr_rdata_o   : read data, combinational from csr_raddr_i, 0 when no hit
//   csr_hit_o     : csr_raddr_i is an address implemented by this block
//   inst_retire_i : one instruction retired this cycle
//   event_i       : per-cycle event pulses, bit k is event code k+1
//   ovf_irq_o     : counter overflow interrupt (registered)
//
// There is no handshake: a write is a single-cycle strobe that always
// completes, and a read is a pure combinational lookup of registered state.
// ============================================================================
module csr_hpm_counter #(
    parameter int NUM_HPM    = 4,
    parameter int CNT_WIDTH  = 64,
    parameter int NUM_EVENTS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  csr_we_i,
    input  logic [11:0]           csr_waddr_i,
    input  logic [31:0]           csr_wdata_i,
    input  logic [11:0]           csr_raddr_i,
    output logic [31:0]           csr_rdata_o,
    output logic                  csr_hit_o,
    input  logic                  inst_retire_i,
    input  logic [NUM_EVENTS-1:0] event_i,
    output logic                  ovf_irq_o
);

    // Counter array is indexed by the low five address bits, so index 0 is
    // mcycle, 2 is minstret and 3+i is mhpmcounter3+i. Index 1 (time) is not
    // implemented here and is held at zero.
    localparam int NC    = 3 + NUM_HPM;
    localparam int HPM_N = (NUM_HPM > 0) ? NUM_HPM : 1;
    localparam int EW    = $clog2(NUM_EVENTS + 1);

    // Implemented bit positions of mcountinhibit (and of mcounterovf).
    localparam logic [31:0] CNT_MASK =
        32'h5 | (32'((64'd1 << NUM_HPM) - 64'd1) << 3);

    logic [CNT_WIDTH-1:0] cnt_q       [NC];
    logic [CNT_WIDTH-1:0] cnt_d       [NC];
    logic [31:0]          inhibit_q;
    logic [31:0]          inhibit_d;
    logic [EW-1:0]        event_sel_q [HPM_N];
    logic [EW-1:0]        event_sel_d [HPM_N];
    logic [NC-1:0]        cnt_inc;

    // Write address decode: counter groups B00..B1F (low) and B80..B9F (high).
    logic       wr_lo;
    logic       wr_hi;
    logic [4:0] widx;

    assign wr_lo = csr_we_i && (csr_waddr_i[11:5] == 7'h58);
    assign wr_hi = csr_we_i && (csr_waddr_i[11:5] == 7'h5C);
    assign widx  = csr_waddr_i[4:0];

    // ------------------------------------------------------------------------
    // Per-counter increment enables, gated by the registered inhibit bits so
    // an inhibit write takes effect one cycle later.
    // ------------------------------------------------------------------------
    always_comb begin
        cnt_inc    = '0;
        cnt_inc[0] = ~inhibit_q[0];
        cnt_inc[2] = ~inhibit_q[2] & inst_retire_i;
        for (int i = 0; i < NUM_HPM; i++) begin
            // Selector 0 and out-of-range codes never match any event bit.
            for (int e = 0; e < NUM_EVENTS; e++) begin
                if (event_sel_q[i] == EW'(e + 1)) begin
                    cnt_inc[3+i] = ~inhibit_q[3+i] & event_i[e];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Counter next state. A CSR write to either half replaces that half and
    // suppresses the increment; otherwise a single full-width add carries
    // from the low word into the high word in the same cycle.
    // ------------------------------------------------------------------------
    always_comb begin : cnt_next
        logic [63:0] ext;
        ext = '0;
        for (int k = 0; k < NC; k++) begin
            cnt_d[k] = cnt_q[k] + CNT_WIDTH'(cnt_inc[k]);
            ext      = 64'(cnt_q[k]);
            if (k != 1) begin
                if (wr_lo && (widx == 5'(k))) begin
                    ext[31:0] = csr_wdata_i;
                    cnt_d[k]  = ext[CNT_WIDTH-1:0];
                end else if (wr_hi && (widx == 5'(k))) begin
                    ext[63:32] = csr_wdata_i;
                    cnt_d[k]   = ext[CNT_WIDTH-1:0];
                end
            end
        end
        cnt_d[1] = '0;
    end

    // ------------------------------------------------------------------------
    // mcountinhibit and mhpmevent (WARL: codes above NUM_EVENTS store 0).
    // ------------------------------------------------------------------------
    always_comb begin
        inhibit_d = inhibit_q;
        if (csr_we_i && (csr_waddr_i == 12'h320)) begin
            inhibit_d = csr_wdata_i & CNT_MASK;
        end
        for (int i = 0; i < HPM_N; i++) begin
            event_sel_d[i] = event_sel_q[i];
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_we_i && (csr_waddr_i == 12'(12'h323 + i))) begin
                event_sel_d[i] = (csr_wdata_i > 32'(NUM_EVENTS)) ? '0
                                                                 : csr_wdata_i[EW-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NC; k++) begin
                cnt_q[k] <= '0;
            end
            inhibit_q <= '0;
            for (int i = 0; i < HPM_N; i++) begin
                event_sel_q[i] <= '0;
            end
        end else begin
            for (int k = 0; k < NC; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
            inhibit_q <= inhibit_d;
            for (int i = 0; i < HPM_N; i++) begin
                event_sel_q[i] <= event_sel_d[i];
            end
        end
    end

`ifdef HPM_OVF_IRQ_EN
    // ------------------------------------------------------------------------
    // Sticky overflow flags in the mcountinhibit bit layout. A wrap is an
    // increment from all ones that lands on zero; a write always leaves the
    // other half non-zero, so cnt_d == 0 only happens through the increment.
    // A same-cycle wrap wins over a write-1-to-clear.
    // ------------------------------------------------------------------------
    logic [31:0] ovf_q;
    logic [31:0] ovf_d;
    logic        irq_q;

    always_comb begin
        ovf_d = ovf_q;
        if (csr_we_i && (csr_waddr_i == 12'h7C0)) begin
            ovf_d = ovf_q & ~csr_wdata_i;
        end
        for (int k = 0; k < NC; k++) begin
            if (cnt_inc[k] && (&cnt_q[k]) && (cnt_d[k] == '0)) begin
                ovf_d[k] = 1'b1;
            end
        end
        ovf_d = ovf_d & CNT_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
            irq_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            irq_q <= |ovf_d;
        end
    end

    assign ovf_irq_o = irq_q;
`else
    assign ovf_irq_o = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // Read mux. Machine counters (B00/B80) and their user shadows (C00/C80)
    // return the same registered value; bit 7 of the address picks the half.
    // ------------------------------------------------------------------------
    always_comb begin : rd_mux
        logic [63:0] ext;
        logic [6:0]  grp;
        ext         = '0;
        grp         = csr_raddr_i[11:5];
        csr_rdata_o = '0;
        csr_hit_o   = 1'b0;
        if ((grp == 7'h58) || (grp == 7'h5C) || (grp == 7'h60) || (grp == 7'h64)) begin
            for (int k = 0; k < NC; k++) begin
                if ((k != 1) && (csr_raddr_i[4:0] == 5'(k))) begin
                    ext         = 64'(cnt_q[k]);
                    csr_hit_o   = 1'b1;
                    csr_rdata_o = csr_raddr_i[7] ? ext[63:32] : ext[31:0];
                end
            end
        end
        if (csr_raddr_i == 12'h320) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = inhibit_q;
        end
        for (int i = 0; i < NUM_HPM; i++) begin
            if (csr_raddr_i == 12'(12'h323 + i)) begin
                csr_hit_o   = 1'b1;
                csr_rdata_o = 32'(event_sel_q[i]);
            end
        end
`ifdef HPM_OVF_IRQ_EN
        if (csr_raddr_i == 12'h7C0) begin
            csr_hit_o   = 1'b1;
            csr_rdata_o = ovf_q;
        end
`endif
    end

endmodule
